// File: rtl/data_mem_pkg.sv
// Shared widths and word/address types for the processor data memory.
package data_mem_pkg;
    localparam int DM_W = 8;
    localparam int DM_A = 8;

    typedef logic [DM_W-1:0] dm_word_t;
    typedef logic [DM_A-1:0] dm_addr_t;
endpackage

// File: rtl/data_mem.sv
// Data memory: combinational read, one-edge write, synchronous clear on Reset (priority over writes).
// Optional DATA_MEM_TRACE_EN prints address/old/new for every committed write (simulation only).
module data_mem
    import data_mem_pkg::*;
#(
    parameter int W = DM_W,
    parameter int A = DM_A
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [A-1:0] DataAddress,
    input  logic         WriteEn,
    input  logic [W-1:0] DataIn,
    output logic [W-1:0] DataOut
);
    localparam int DEPTH = 1 << A;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WriteEn) begin
            mem[DataAddress] <= DataIn;
        end
    end

    // No bypass: a same-cycle write shows up only after the edge.
    assign DataOut = mem[DataAddress];

`ifdef DATA_MEM_TRACE_EN
    always @(posedge Clk) begin
        if (!Reset && WriteEn) begin
            $display("[data_mem] addr=%0h old=%0h new=%0h", DataAddress, mem[DataAddress], DataIn);
        end
    end
`else
`endif
endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected reads, a negedge monitor pops and compares.
module tb_data_mem;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] DataAddress = '0;
    logic       WriteEn = 1'b0;
    logic [7:0] DataIn = '0;
    logic [7:0] DataOut;

    logic       chk = 1'b0;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    string      name_q [$];
    int         tests = 0;
    int         fails = 0;

    data_mem dut (
        .Clk(Clk),
        .Reset(Reset),
        .DataAddress(DataAddress),
        .WriteEn(WriteEn),
        .DataIn(DataIn),
        .DataOut(DataOut)
    );

    always #5 Clk = ~Clk;

    // One clock cycle of stimulus; the expected read is the value before this cycle's edge.
    task automatic cycle(input logic rst, input logic we, input logic [7:0] addr,
                         input logic [7:0] din, input logic check, input string nm);
        @(posedge Clk);
        #1;
        Reset       = rst;
        WriteEn     = we;
        DataAddress = addr;
        DataIn      = din;
        chk         = check;
        if (check) begin
            exp_q.push_back(model[addr]);
            name_q.push_back(nm);
        end
        if (rst) begin
            foreach (model[i]) model[i] = 8'h00;
        end else if (we) begin
            model[addr] = din;
        end
    endtask

    task automatic rd(input logic [7:0] addr, input string nm);
        cycle(1'b0, 1'b0, addr, 8'h00, 1'b1, nm);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] din);
        cycle(1'b0, 1'b1, addr, din, 1'b0, "");
    endtask

    // Monitor: samples DataOut mid-cycle whenever the stimulus flagged a read.
    initial begin
        logic [7:0] e;
        string      n;
        forever begin
            @(negedge Clk);
            if (chk) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: got %0h, no expected value queued", DataOut);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (DataOut !== e) begin
                        fails++;
                        $display("FAIL %s addr=%0h: got %0h expected %0h", n, DataAddress, DataOut, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        foreach (model[i]) model[i] = 8'hxx;

        cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "");
        for (int i = 0; i < 256; i++) rd(8'(i), "reset_sweep");

        cycle(1'b0, 1'b1, 8'h10, 8'hA5, 1'b1, "write_old");
        rd(8'h10, "write_read");
        rd(8'h11, "write_neighbour");

        wr(8'h20, 8'h11);
        cycle(1'b0, 1'b1, 8'h20, 8'h22, 1'b1, "rdw_before");
        rd(8'h20, "rdw_after");

        wr(8'h05, 8'h3C);
        wr(8'h30, 8'h9A);
        cycle(1'b1, 1'b1, 8'h30, 8'hFF, 1'b0, "");
        for (int i = 0; i < 256; i++) rd(8'(i), "reset_priority");

        wr(8'h00, 8'h01);
        wr(8'hFF, 8'hFE);
        rd(8'h00, "boundary_lo");
        rd(8'hFF, "boundary_hi");
        rd(8'h01, "boundary_lo_nb");
        rd(8'hFE, "boundary_hi_nb");

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h40, 8'h77, 1'b1, "we_low");
        rd(8'h40, "we_low_after");

        wr(8'h50, 8'h12);
        wr(8'h50, 8'h34);
        rd(8'h50, "b2b_last_wins");

        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            d = 8'($urandom);
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), a, d, 1'b1, "random");
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "");
        @(posedge Clk);
        @(posedge Clk);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
